// File: rtl/reverb_tap_loader.sv
// Reverb tap loader: holds a host-written FIR tap table and replays it in address
// order to the reverb core over valid/ready, then waits for the core's done flag.
`timescale 1ns/1ps
module reverb_tap_loader #(
  parameter int G_NUM_TAPS_LOG2 = 4,
  parameter int G_TAP_WIDTH     = 16,
  parameter int G_DONE_TIMEOUT  = 1024
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       cfg_wr_en,
  input  logic [G_NUM_TAPS_LOG2-1:0] cfg_wr_addr,
  input  logic [G_TAP_WIDTH-1:0]     cfg_wr_data,
  input  logic                       load_start,
  output logic                       busy,
  output logic                       load_done,
  output logic                       load_err,
  output logic [G_TAP_WIDTH-1:0]     tap_dout,
  output logic                       tap_dout_valid,
  input  logic                       tap_dout_ready,
  input  logic                       tap_dout_done
);

  localparam int DEPTH = 1 << G_NUM_TAPS_LOG2;
  localparam int CNT_W = $clog2(G_DONE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(G_DONE_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT_DONE} state_e;

  state_e                     state_q, state_d;
  logic [G_NUM_TAPS_LOG2-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [G_TAP_WIDTH-1:0]     tap_q, tap_d;
  logic                       valid_q, valid_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
  logic [G_TAP_WIDTH-1:0]     table_q [DEPTH];
  logic [G_TAP_WIDTH-1:0]     table_d [DEPTH];

  logic handshake;
  logic last_idx;
  logic timed_out;

  assign handshake = valid_q & tap_dout_ready;
  assign last_idx  = &idx_q;
  assign timed_out = (cnt_q == CNT_LAST);

  // State register and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      tap_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      // NOTE: the table is a flop array, not a RAM macro, so it can and must be
      // cleared by reset; a RAM-inferred table could not honour that.
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tap_q   <= tap_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
      table_q <= table_d;
    end
  end

  // Next-state logic; enable=0 overrides everything and parks the FSM in IDLE.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:      if (load_start) state_d = S_STREAM;
        S_STREAM:    if (handshake && last_idx) state_d = S_WAIT_DONE;
        S_WAIT_DONE: if (tap_dout_done || timed_out) state_d = S_IDLE;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: every target gets a hold default first so no path infers a latch.
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tap_d   = tap_q;
    valid_d = valid_q;
    done_d  = done_q;
    err_d   = err_q;
    table_d = table_q;

    if (cfg_wr_en && state_q == S_IDLE) table_d[cfg_wr_addr] = cfg_wr_data;

    if (!enable) begin
      valid_d = 1'b0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_start) begin
            // Reads table_q, so a same-cycle write to address 0 is not seen here.
            tap_d   = table_q[0];
            valid_d = 1'b1;
            idx_d   = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
          end
        end
        S_STREAM: begin
          if (handshake) begin
            if (last_idx) begin
              valid_d = 1'b0;
              cnt_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
              tap_d = table_q[idx_q + 1'b1];
            end
          end
        end
        S_WAIT_DONE: begin
          if (tap_dout_done)  done_d = 1'b1;
          else if (timed_out) err_d  = 1'b1;
          else                cnt_d  = cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output decode.
  always_comb begin
    busy           = (state_q != S_IDLE);
    load_done      = done_q;
    load_err       = err_q;
    tap_dout       = tap_q;
    tap_dout_valid = valid_q;
  end

endmodule

// File: tb/tb_reverb_tap_loader.sv
// Self-checking bench for reverb_tap_loader: a plain array models the tap table
// and a queue holds the tap sequence each load must deliver.
`timescale 1ns/1ps
module tb_reverb_tap_loader;

  localparam int LOG2  = 4;
  localparam int DEPTH = 1 << LOG2;
  localparam int TW    = 16;
  localparam int TO    = 8;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            enable;
  logic            cfg_wr_en;
  logic [LOG2-1:0] cfg_wr_addr;
  logic [TW-1:0]   cfg_wr_data;
  logic            load_start;
  logic            busy, load_done, load_err;
  logic [TW-1:0]   tap_dout;
  logic            tap_dout_valid;
  logic            tap_dout_ready;
  logic            tap_dout_done;

  int tests  = 0;
  int failed = 0;
  int mtab [DEPTH];
  int exp_q[$];
  int got_q[$];
  int last_cycles;

  reverb_tap_loader #(
    .G_NUM_TAPS_LOG2(LOG2), .G_TAP_WIDTH(TW), .G_DONE_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .load_start(load_start), .busy(busy), .load_done(load_done), .load_err(load_err),
    .tap_dout(tap_dout), .tap_dout_valid(tap_dout_valid),
    .tap_dout_ready(tap_dout_ready), .tap_dout_done(tap_dout_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, failed=%0d", failed);
    $fatal(1, "watchdog expired");
  end

  task automatic build_exp();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(mtab[i]);
  endtask

  // Idle-only table write; the model follows because the bench knows the block is idle.
  task automatic write_tap(input int addr, input int data);
    cfg_wr_en = 1'b1; cfg_wr_addr = LOG2'(addr); cfg_wr_data = TW'(data);
    @(negedge clk);
    cfg_wr_en = 1'b0;
    mtab[addr] = data;
  endtask

  task automatic start_load(input string name, input bit wr, input int addr, input int data);
    enable = 1'b1; load_start = 1'b1;
    cfg_wr_en = wr; cfg_wr_addr = LOG2'(addr); cfg_wr_data = TW'(data);
    @(negedge clk);
    load_start = 1'b0; cfg_wr_en = 1'b0;
    tests++;
    if (tap_dout_valid !== 1'b1 || busy !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0) begin
      failed++;
      $display("FAIL %s start: valid=%b busy=%b done=%b err=%b, want 1 1 0 0",
               name, tap_dout_valid, busy, load_done, load_err);
    end
  endtask

  // mode 0: ready=1, mode 1: ready pattern 1,0,0, mode 2: random ready.
  task automatic collect(input string name, input int mode, input int abort_at, input int inject_at);
    bit pend, rdy, aborted;
    logic [TW-1:0] pdata;
    int cyc;
    got_q.delete(); pend = 0; aborted = 0; pdata = '0; cyc = 0;
    while (got_q.size() < DEPTH && cyc < 400 && !aborted) begin
      tests++;
      if (tap_dout_valid !== 1'b1 || busy !== 1'b1) begin
        failed++;
        $display("FAIL %s stream cyc %0d: valid=%b busy=%b, want 1 1", name, cyc, tap_dout_valid, busy);
      end
      if (pend) begin
        tests++;
        if (tap_dout !== pdata) begin
          failed++;
          $display("FAIL %s hold cyc %0d: data=%h, want %h", name, cyc, tap_dout, pdata);
        end
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      tap_dout_ready = rdy;
      if (cyc == inject_at) begin
        cfg_wr_en = 1'b1; cfg_wr_addr = 4'd5; cfg_wr_data = 16'hDEAD; load_start = 1'b1;
      end else begin
        cfg_wr_en = 1'b0; load_start = 1'b0;
      end
      if (tap_dout_valid && rdy) begin
        got_q.push_back(int'(tap_dout));
        if (got_q.size() == abort_at) begin
          enable = 1'b0; aborted = 1;
        end
      end
      pend = tap_dout_valid && !rdy;
      pdata = tap_dout;
      cyc++;
      @(negedge clk);
    end
    cfg_wr_en = 1'b0; load_start = 1'b0; tap_dout_ready = 1'b0;
    last_cycles = cyc;
    tests++;
    if (aborted) begin
      if (tap_dout_valid !== 1'b0 || busy !== 1'b0) begin
        failed++;
        $display("FAIL %s abort: valid=%b busy=%b, want 0 0", name, tap_dout_valid, busy);
      end
      enable = 1'b1;
    end else if (got_q.size() != DEPTH || tap_dout_valid !== 1'b0 || busy !== 1'b1) begin
      failed++;
      $display("FAIL %s end: taps=%0d valid=%b busy=%b, want %0d 0 1",
               name, got_q.size(), tap_dout_valid, busy, DEPTH);
    end
    for (int i = 0; i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin
        failed++;
        $display("FAIL %s tap %0d: got %h, want %h", name, i, got_q[i], exp_q[i]);
      end
    end
  endtask

  // Core raises done after `delay` idle cycles in WAIT_DONE (delay <= TO-1).
  task automatic finish_done(input string name, input int delay);
    tap_dout_done = 1'b0;
    repeat (delay) @(negedge clk);
    tests++;
    if (busy !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0) begin
      failed++;
      $display("FAIL %s pre-done: busy=%b done=%b err=%b, want 1 0 0", name, busy, load_done, load_err);
    end
    tap_dout_done = 1'b1;
    @(negedge clk);
    tap_dout_done = 1'b0;
    tests++;
    if (load_done !== 1'b1 || busy !== 1'b0 || load_err !== 1'b0) begin
      failed++;
      $display("FAIL %s done: done=%b busy=%b err=%b, want 1 0 0", name, load_done, busy, load_err);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b1; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
    load_start = 1'b0; tap_dout_ready = 1'b0; tap_dout_done = 1'b0;
    for (int i = 0; i < DEPTH; i++) mtab[i] = 0;
    #1;
    tests++;
    if (tap_dout !== '0 || tap_dout_valid !== 1'b0 || busy !== 1'b0 || load_done !== 1'b0 || load_err !== 1'b0) begin
      failed++;
      $display("FAIL reset: dout=%h valid=%b busy=%b done=%b err=%b, want all 0",
               tap_dout, tap_dout_valid, busy, load_done, load_err);
    end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    for (int i = 0; i < DEPTH; i++) write_tap(i, 'h1000 + i);
    build_exp();
    start_load("basic", 0, 0, 0);
    collect("basic", 0, -1, -1);
    tests++;
    if (last_cycles != DEPTH) begin
      failed++;
      $display("FAIL basic throughput: %0d cycles, want %0d", last_cycles, DEPTH);
    end
    finish_done("basic", 3);
  endtask

  task automatic test_back_to_back();
    build_exp();
    start_load("b2b", 0, 0, 0);
    collect("b2b_backpressure", 1, -1, -1);
    finish_done("b2b", int'($urandom_range(0, TO - 2)));
  endtask

  task automatic test_ignored_busy();
    build_exp();
    start_load("busy_ign", 0, 0, 0);
    collect("busy_ign", 0, -1, 3);
    finish_done("busy_ign", 1);
    start_load("busy_ign2", 0, 0, 0);
    collect("busy_ign2", 2, -1, -1);
    finish_done("busy_ign2_prio", TO - 1);
  endtask

  task automatic test_timeout();
    build_exp();
    start_load("timeout", 0, 0, 0);
    collect("timeout", 2, -1, -1);
    tap_dout_done = 1'b0;
    repeat (TO - 1) @(negedge clk);
    tests++;
    if (busy !== 1'b1 || load_err !== 1'b0) begin
      failed++;
      $display("FAIL timeout early: busy=%b err=%b, want 1 0", busy, load_err);
    end
    @(negedge clk);
    tests++;
    if (load_err !== 1'b1 || busy !== 1'b0 || load_done !== 1'b0) begin
      failed++;
      $display("FAIL timeout: err=%b busy=%b done=%b, want 1 0 0", load_err, busy, load_done);
    end
    start_load("timeout_clear", 0, 0, 0);
    collect("timeout_clear", 0, -1, -1);
    finish_done("timeout_clear", 0);
  endtask

  task automatic test_disabled_start();
    enable = 1'b0; load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0; enable = 1'b1;
    tests++;
    if (busy !== 1'b0 || tap_dout_valid !== 1'b0) begin
      failed++;
      $display("FAIL disabled_start: busy=%b valid=%b, want 0 0", busy, tap_dout_valid);
    end
  endtask

  task automatic test_abort();
    build_exp();
    start_load("abort", 0, 0, 0);
    collect("abort", 0, 7, -1);
    start_load("abort_restart", 0, 0, 0);
    collect("abort_restart", 2, -1, -1);
    finish_done("abort_restart", 2);
  endtask

  task automatic test_write_with_start();
    int old0, nv, k;
    for (int i = 0; i < DEPTH; i++) write_tap(i, int'($urandom_range(1, 'hFFFF)));
    old0 = mtab[0];
    nv = int'($urandom_range(1, 'hFFFF));
    build_exp();
    exp_q[0] = old0;
    mtab[0] = nv;
    start_load("wr_start0", 1, 0, nv);
    collect("wr_start0", 2, -1, -1);
    finish_done("wr_start0", 1);
    k  = int'($urandom_range(1, DEPTH - 1));
    nv = int'($urandom_range(1, 'hFFFF));
    mtab[k] = nv;
    build_exp();
    start_load("wr_startk", 1, k, nv);
    collect("wr_startk", 0, -1, -1);
    finish_done("wr_startk", 4);
  endtask

  task automatic test_random_loads();
    for (int n = 0; n < 4; n++) begin
      for (int j = 0; j < 4; j++) write_tap(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 'hFFFF)));
      build_exp();
      start_load("random", 0, 0, 0);
      collect("random", 2, -1, -1);
      finish_done("random", int'($urandom_range(0, TO - 1)));
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < DEPTH; i++) write_tap(i, int'($urandom_range(1, 'hFFFF)));
    build_exp();
    start_load("reset_mid", 0, 0, 0);
    tap_dout_ready = 1'b1;
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (tap_dout !== '0 || tap_dout_valid !== 1'b0 || busy !== 1'b0 || load_done !== 1'b0 || load_err !== 1'b0) begin
      failed++;
      $display("FAIL reset_mid: dout=%h valid=%b busy=%b done=%b err=%b, want all 0",
               tap_dout, tap_dout_valid, busy, load_done, load_err);
    end
    @(negedge clk);
    reset_n = 1'b1; tap_dout_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mtab[i] = 0;
    @(negedge clk);
    build_exp();
    start_load("reset_zero", 0, 0, 0);
    collect("reset_zero", 1, -1, -1);
    finish_done("reset_zero", 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignored_busy();
    test_timeout();
    test_disabled_start();
    test_abort();
    test_write_with_start();
    test_random_loads();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/reverb_tap_loader.md
# reverb_tap_loader

Streams a host-programmed set of FIR coefficients into the reverb core's tap-load port. The block sits directly upstream of the reverb core's `tap_din` / `tap_din_valid` / `tap_din_ready` / `tap_din_done` interface. It holds a local tap table written by the control plane. On command, it replays the table in address order over a valid/ready handshake, then waits for the core to report that loading is complete.

## Interface

Parameters:
- `G_NUM_TAPS_LOG2`, default 4: log2 of the table depth; depth = 2^`G_NUM_TAPS_LOG2`. Must equal the core's `G_NUM_STAGES_LOG2` + `G_STAGE_DEPTH_LOG2`.
- `G_TAP_WIDTH`, default 16: tap width in bits.
- `G_DONE_TIMEOUT`, default 1024: maximum cycles spent in WAIT_DONE before the load is flagged as failed. Must be ≥ 1.

Ports:
- `clk`, in, 1: single clock domain.
- `reset_n`, in, 1: asynchronous reset, active-low.
- `enable`, in, 1: synchronous enable; 0 aborts any load.
- `cfg_wr_en`, in, 1: table write strobe.
- `cfg_wr_addr`, in, `G_NUM_TAPS_LOG2`: table write address.
- `cfg_wr_data`, in, `G_TAP_WIDTH`: table write data.
- `load_start`, in, 1: single-cycle command to begin streaming.
- `busy`, out, 1: high in STREAM and WAIT_DONE.
- `load_done`, out, 1: sticky; the last load completed.
- `load_err`, out, 1: sticky; the last load timed out.
- `tap_dout`, out, `G_TAP_WIDTH`: tap to the core.
- `tap_dout_valid`, out, 1: tap valid.
- `tap_dout_ready`, in, 1: core ready.
- `tap_dout_done`, in, 1: core reports all taps loaded.

## Operation

- **Table.** Register array of 2^`G_NUM_TAPS_LOG2` × `G_TAP_WIDTH`. Cleared to 0 on reset.
  - A write takes effect on the clock edge where `cfg_wr_en`=1, only in IDLE.
  - Writes while `busy`=1 are dropped.
- **States:** IDLE, STREAM, WAIT_DONE.
- **IDLE → STREAM** on `load_start`=1 with `enable`=1. On that edge:
  - `tap_dout` ← table[0], `tap_dout_valid` ← 1, index ← 0.
  - `load_done` ← 0, `load_err` ← 0.
- **STREAM.** On each handshake (`tap_dout_valid` & `tap_dout_ready`):
  - If index = depth−1: `tap_dout_valid` ← 0, timeout counter ← 0, go to WAIT_DONE.
  - Otherwise: index ← index+1, `tap_dout` ← table[index+1], `tap_dout_valid` stays 1.
- **Valid/ready rules.**
  - `tap_dout` and `tap_dout_valid` are held stable while `tap_dout_ready`=0.
  - Valid never drops before a handshake.
  - Exactly depth handshakes occur per load.
- **WAIT_DONE.** Each cycle:
  - If `tap_dout_done`=1: `load_done` ← 1, go to IDLE.
  - Else if counter = `G_DONE_TIMEOUT`−1: `load_err` ← 1, go to IDLE.
  - Else counter ← counter+1.
  - Done takes priority over timeout in the same cycle.
- **Ignored starts.** `load_start` is ignored outside IDLE; it is not queued.
- **`enable`=0 (abort).** Any state goes to IDLE on the next edge:
  - `tap_dout_valid` ← 0 and the index is cleared.
  - `load_done` and `load_err` keep their values.
  - Table contents are preserved.
  - `load_start` is ignored while `enable`=0.
- **`busy`** is decoded directly from state: (state ≠ IDLE).
- **Tap data** passes through unmodified. No sign handling and no arithmetic are performed.

## Timing

- **Reset values.** Asserting `reset_n` low immediately forces:
  - `tap_dout` = 0, `tap_dout_valid` = 0.
  - `busy` = 0, `load_done` = 0, `load_err` = 0.
  - State = IDLE, table all zero.
  - Deassertion is assumed synchronised externally.
- **Start latency.** `load_start` sampled at edge k gives `tap_dout_valid`=1 and `busy`=1 after edge k.
- **Throughput.** With `tap_dout_ready` held at 1, one tap per cycle. Depth 16 streams in 16 consecutive cycles.
- **Stream-to-wait.** After the last handshake edge, `tap_dout_valid`=0 and the block is in WAIT_DONE. `tap_dout_done` is first examined in the following cycle.
- **Done/error timing.**
  - `load_done` rises on the edge after `tap_dout_done` is sampled high in WAIT_DONE.
  - `busy` falls on that same edge.
- **Timeout timing.** With `tap_dout_done` held at 0, `load_err` rises exactly `G_DONE_TIMEOUT` cycles after WAIT_DONE entry.
- **Back-to-back loads.** A new `load_start` is accepted in the first IDLE cycle after a completion.
- **Write and start in the same IDLE cycle.** The write lands in the table. The streamed value for that address is the pre-write value if the address is 0; otherwise it is the new value.
- **Reset mid-load.** Outputs return to their reset values immediately and the table is cleared.

## Test plan

- **Basic load.** Reset, then write table[i] = 0x1000+i for i = 0..15, then pulse `load_start` with `tap_dout_ready`=1. Require:
  - 16 handshakes carrying 0x1000..0x100F in order on consecutive cycles.
  - `tap_dout_done` asserted 3 cycles later gives `load_done`=1, `busy`=0.
- **Backpressure.** Toggle `tap_dout_ready` in the pattern 1,0,0,1,… Require:
  - `tap_dout` stable while ready is 0.
  - Exactly 16 transfers with no duplicates or gaps.
  - `tap_dout_valid` never deasserts before its handshake.
- **Timeout.** Set `G_DONE_TIMEOUT`=8 and never assert `tap_dout_done`. Require:
  - `load_err`=1 and `busy`=0 exactly 8 cycles after WAIT_DONE entry.
  - `load_done`=0.
  - The next `load_start` clears `load_err`.
- **Ignored accesses while busy.** During STREAM, write table[5] = 0xDEAD and pulse `load_start`. Require:
  - The stream is unchanged.
  - A subsequent load shows table[5] = 0x1005.
- **Abort.** Drop `enable` to 0 at handshake 7. Require:
  - Next cycle: `tap_dout_valid`=0, `busy`=0.
  - After re-enabling and restarting, the full 16-tap sequence begins at table[0].
- **Reset mid-stream.** Assert `reset_n`=0 mid-stream. Require:
  - Outputs are zero immediately.
  - After release, a load streams all-zero taps.
